// File: rtl/sng_pkg.sv
// Shared definitions for the SNG frame loader and the 4-input sorter.
package sng_pkg;

    localparam int SNG_WIDTH = 10;
    localparam int NUM_LANES = 4;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/sng_frame_loader.sv
// Groups a stream of SNG words into 4-word frames (block or sliding window)
// and presents them as registered parallel words with a valid/ready handshake.
module sng_frame_loader
    import sng_pkg::*;
#(
    parameter int WIDTH = SNG_WIDTH,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             slide,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_a,
    output logic [WIDTH-1:0] m_b,
    output logic [WIDTH-1:0] m_c,
    output logic [WIDTH-1:0] m_d,
    output logic [CNT_W-1:0] frame_cnt
);

    state_t     state_q;
    state_t     state_d;
    logic [1:0] cnt_q;
    logic [1:0] cnt_d;
    logic       mode_q;
    logic       acc;
    logic       cons;
    logic       shift_en;
    logic       latch_mode;
    logic       count_en;

    assign m_valid = (state_q == HOLD);
    assign s_ready = !m_valid || m_ready;
    assign acc     = s_valid && s_ready;
    assign cons    = m_valid && m_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // In HOLD cnt stays at 3; sliding consume falls back to FILL with 3 kept.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush) begin
            state_d = FILL;
            cnt_d   = 2'd0;
        end else begin
            unique case (state_q)
                FILL: begin
                    if (acc) begin
                        if (cnt_q == 2'd3) state_d = HOLD;
                        else cnt_d = cnt_q + 2'd1;
                    end
                end
                HOLD: begin
                    if (cons) begin
                        if (mode_q) begin
                            if (!acc) begin
                                state_d = FILL;
                                cnt_d   = 2'd3;
                            end
                        end else begin
                            state_d = FILL;
                            cnt_d   = acc ? 2'd1 : 2'd0;
                        end
                    end
                end
            endcase
        end
    end

    // A block-mode consume with accept starts a fresh frame, so it latches mode too.
    always_comb begin
        shift_en   = 1'b0;
        latch_mode = 1'b0;
        count_en   = 1'b0;
        if (!flush) begin
            shift_en   = acc;
            count_en   = cons;
            latch_mode = acc && ((state_q == FILL && cnt_q == 2'd0) ||
                                 (state_q == HOLD && !mode_q));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_a <= '0;
            m_b <= '0;
            m_c <= '0;
            m_d <= '0;
        end else if (flush) begin
            m_a <= '0;
            m_b <= '0;
            m_c <= '0;
            m_d <= '0;
        end else if (shift_en) begin
            m_a <= m_b;
            m_b <= m_c;
            m_c <= m_d;
            m_d <= s_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q    <= 1'b0;
            frame_cnt <= '0;
        end else begin
            if (latch_mode) mode_q <= slide;
            if (count_en) frame_cnt <= frame_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_sng_frame_loader.sv
// Directed and random stimulus for sng_frame_loader against a queue-based window model.
module tb_sng_frame_loader;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic       slide;
    logic       s_valid;
    logic       s_ready;
    logic [9:0] s_data;
    logic       m_valid;
    logic       m_ready;
    logic [9:0] m_a;
    logic [9:0] m_b;
    logic [9:0] m_c;
    logic [9:0] m_d;
    logic [15:0] frame_cnt;

    int checks = 0;
    int errors = 0;
    bit chk_on = 0;

    logic [9:0]  mq[$];
    bit          mmode;
    logic [15:0] mf;
    bit          mclr;

    sng_frame_loader #(.WIDTH(10), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .slide(slide),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready),
        .m_a(m_a), .m_b(m_b), .m_c(m_c), .m_d(m_d),
        .frame_cnt(frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, got, exp, $time);
        end
    endtask

    task automatic chk_frame(input string n, input int a, input int b, input int c, input int d);
        chk({n, "_valid"}, 32'(m_valid), 32'd1);
        chk({n, "_a"}, 32'(m_a), 32'(a));
        chk({n, "_b"}, 32'(m_b), 32'(b));
        chk({n, "_c"}, 32'(m_c), 32'(c));
        chk({n, "_d"}, 32'(m_d), 32'(d));
    endtask

    task automatic cyc(input logic sv, input logic [9:0] d, input logic mr,
                       input logic sl, input logic fl);
        s_valid = sv;
        s_data  = d;
        m_ready = mr;
        slide   = sl;
        flush   = fl;
        @(posedge clk);
        #1;
    endtask

    // Window model: consume first (drop all or drop oldest), then append accepted word.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            mmode = 1'b0;
            mf    = 16'd0;
            mclr  = 1'b1;
        end else if (flush) begin
            mq.delete();
            mclr = 1'b1;
        end else begin
            bit v;
            bit cons;
            bit acc;
            v    = (mq.size() == 4);
            cons = v && m_ready;
            acc  = s_valid && (!v || m_ready);
            if (cons) begin
                mf = mf + 16'd1;
                if (mmode) void'(mq.pop_front());
                else mq.delete();
            end
            if (acc) begin
                if (mq.size() == 0) mmode = slide;
                mq.push_back(s_data);
                mclr = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on && rst_n) begin
            bit v;
            v = (mq.size() == 4);
            chk("m_valid", 32'(m_valid), 32'(v));
            chk("s_ready", 32'(s_ready), 32'(!v || m_ready));
            chk("frame_cnt", 32'(frame_cnt), 32'(mf));
            if (v) begin
                chk("m_a", 32'(m_a), 32'(mq[0]));
                chk("m_b", 32'(m_b), 32'(mq[1]));
                chk("m_c", 32'(m_c), 32'(mq[2]));
                chk("m_d", 32'(m_d), 32'(mq[3]));
            end
            if (mclr) chk("cleared", 32'({m_a, m_b, m_c, m_d}), 32'd0);
        end
    end

    initial begin
        rst_n   = 1'b0;
        flush   = 1'b0;
        slide   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        chk_on = 1'b1;
        chk("rst_mvalid", 32'(m_valid), 32'd0);
        chk("rst_sready", 32'(s_ready), 32'd1);
        chk("rst_fcnt", 32'(frame_cnt), 32'd0);

        // reset in the middle of a fill
        cyc(1, 10'd7, 0, 0, 0);
        cyc(1, 10'd8, 0, 0, 0);
        s_valid = 1'b0;
        rst_n   = 1'b0;
        #2;
        chk("midrst_mvalid", 32'(m_valid), 32'd0);
        chk("midrst_slots", 32'({m_a, m_b, m_c, m_d}), 32'd0);
        chk("midrst_fcnt", 32'(frame_cnt), 32'd0);
        chk("midrst_sready", 32'(s_ready), 32'd1);
        rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) cyc(1, 10'(i), 0, 0, 0);
        chk_frame("f1234", 1, 2, 3, 4);
        cyc(0, 10'd0, 1, 0, 0);
        chk("f1234_cnt", 32'(frame_cnt), 32'd1);

        // block mode streaming
        for (int i = 10; i <= 17; i++) begin
            cyc(1, 10'(i), 1, 0, 0);
            if (i == 13) chk_frame("blk0", 10, 11, 12, 13);
            if (i == 14) chk("blk0_once", 32'(m_valid), 32'd0);
            if (i == 17) chk_frame("blk1", 14, 15, 16, 17);
        end
        cyc(0, 10'd0, 1, 0, 0);
        chk("blk_cnt", 32'(frame_cnt), 32'd3);

        // backpressure
        for (int i = 5; i <= 8; i++) cyc(1, 10'(i), 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            cyc(1, 10'd9, 0, 0, 0);
            chk("bp_sready", 32'(s_ready), 32'd0);
            chk_frame("bp_hold", 5, 6, 7, 8);
        end
        cyc(1, 10'd9, 1, 0, 0);
        chk("bp_release", 32'(m_valid), 32'd0);
        chk("bp_cnt", 32'(frame_cnt), 32'd4);
        for (int i = 10; i <= 12; i++) cyc(1, 10'(i), 0, 0, 0);
        chk_frame("bp_next", 9, 10, 11, 12);
        cyc(0, 10'd0, 1, 0, 0);

        // sliding mode
        for (int i = 1; i <= 7; i++) begin
            cyc(1, 10'(i), 1, 1, 0);
            if (i >= 4) chk_frame("slide", i - 3, i - 2, i - 1, i);
        end
        cyc(0, 10'd0, 1, 1, 0);
        chk("slide_cnt", 32'(frame_cnt), 32'd9);
        cyc(0, 10'd0, 0, 0, 1);
        chk("flush_idle", 32'(m_valid), 32'd0);

        // mode latched on the first word of a frame only
        cyc(1, 10'd20, 0, 0, 0);
        cyc(1, 10'd21, 0, 0, 0);
        cyc(1, 10'd22, 0, 1, 0);
        cyc(1, 10'd23, 0, 1, 0);
        chk_frame("latch0", 20, 21, 22, 23);
        cyc(1, 10'd24, 1, 1, 0);
        chk("latch_block", 32'(m_valid), 32'd0);
        for (int i = 25; i <= 27; i++) cyc(1, 10'(i), 0, 0, 0);
        chk_frame("latch1", 24, 25, 26, 27);
        cyc(1, 10'd28, 1, 0, 0);
        chk_frame("latch_slide", 25, 26, 27, 28);
        chk("latch_cnt", 32'(frame_cnt), 32'd11);

        // flush beats simultaneous consume and accept
        cyc(1, 10'd29, 1, 0, 1);
        chk("flush_mvalid", 32'(m_valid), 32'd0);
        chk("flush_cnt", 32'(frame_cnt), 32'd11);
        chk("flush_slots", 32'({m_a, m_b, m_c, m_d}), 32'd0);

        // frame counter wrap
        for (int n = 0; n < 70000 && mf != 16'hFFFF; n++) cyc(1, 10'(n), 1, 1, 0);
        chk("wrap_pre", 32'(frame_cnt), 32'h0000FFFF);
        cyc(1, 10'd5, 1, 1, 0);
        chk("wrap_post", 32'(frame_cnt), 32'd0);
        cyc(0, 10'd0, 0, 0, 1);

        // randomized traffic
        for (int n = 0; n < 3000; n++)
            cyc($urandom_range(0, 3) != 0, 10'($urandom), $urandom_range(0, 3) != 0,
                $urandom_range(0, 1) == 1, $urandom_range(0, 40) == 0);

        cyc(0, 10'd0, 0, 0, 0);
        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
